// File: rtl/width_down_serializer.sv
// width_down_serializer
//
// Takes IN_W-bit words on a valid/enable handshake and sends each one out as
// RATIO = IN_W/OUT_W narrower beats on the same kind of handshake. The final
// beat of each word is flagged with last_down.
//
// A new word can be accepted on the same cycle that the last beat of the
// current word is accepted. When downstream never stalls, this gives one word
// every RATIO cycles with no idle cycle between words.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      synchronous, active-low reset
//   v_up       word valid from upstream
//   d_up       word data from upstream (IN_W bits)
//   e_up       enable to upstream; a word transfers when v_up & e_up
//   v_down     beat valid to downstream
//   d_down     beat data to downstream (OUT_W bits)
//   last_down  high with the final beat of the current word
//   e_down     enable from downstream; a beat transfers when v_down & e_down
//
// Parameters:
//   IN_W       input word width
//   OUT_W      output beat width; IN_W must be a multiple of it with RATIO >= 2
//   MSB_FIRST  0: low beat first, 1: high beat first
module width_down_serializer #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v_up,
  input  logic [IN_W-1:0]  d_up,
  output logic             e_up,
  output logic             v_down,
  output logic [OUT_W-1:0] d_down,
  output logic             last_down,
  input  logic             e_down
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_bad_ratio
    $error("width_down_serializer: IN_W must be a multiple of OUT_W with RATIO >= 2");
  end

  logic [IN_W-1:0]  sr_p0;
  logic [CNT_W-1:0] cnt;
  logic             v_l;

  logic take_word;
  logic take_beat;

  // The beat being shown always sits at the end of the shift register that
  // faces the output, so d_down is a simple fixed slice.
  if (MSB_FIRST) begin : g_msb
    assign d_down = sr_p0[IN_W-1 -: OUT_W];
  end else begin : g_lsb
    assign d_down = sr_p0[OUT_W-1:0];
  end

  assign v_down    = v_l;
  assign last_down = v_l & (cnt == CNT_LAST);
  // The enable to upstream is combinational on e_down, so a new word can be
  // loaded on the same cycle the final beat leaves.
  assign e_up      = ~v_l | (e_down & last_down);

  assign take_word = v_up & e_up;
  assign take_beat = v_l & e_down;

  // ---- stage p0: shift register, beat counter, occupancy ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_l   <= 1'b0;
      cnt   <= '0;
      sr_p0 <= '0;
    end else if (take_word) begin
      // This covers both an empty buffer and a refill on the final beat.
      sr_p0 <= d_up;
      cnt   <= '0;
      v_l   <= 1'b1;
    end else if (take_beat) begin
      if (cnt == CNT_LAST) begin
        v_l <= 1'b0;
        cnt <= '0;
      end else begin
        sr_p0 <= MSB_FIRST ? (sr_p0 << OUT_W) : (sr_p0 >> OUT_W);
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/width_down_serializer.md
Name: width_down_serializer

Overview:
- Downstream consumer of the single-entry valid/enable timing buffer.
- Takes IN_W-bit words on a v/e handshake and emits them as RATIO = IN_W/OUT_W narrower beats on an identical v/e handshake.
- Flags the final beat of each word.
- Sustains full throughput: one word per RATIO cycles with no bubble between words when downstream never stalls.

Parameters:
- IN_W, 32, input word width.
- OUT_W, 8, output beat width. IN_W must be an integer multiple of OUT_W with RATIO >= 2; otherwise elaboration fails.
- MSB_FIRST, 0, beat order. 0 sends bits [OUT_W-1:0] first; 1 sends bits [IN_W-1:IN_W-OUT_W] first.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- v_up  input  1  word valid from upstream.
- d_up  input  IN_W  word data from upstream.
- e_up  output  1  enable to upstream; a word transfers when v_up & e_up.
- v_down  output  1  beat valid to downstream.
- d_down  output  OUT_W  beat data to downstream.
- last_down  output  1  high with the final beat of the current word.
- e_down  input  1  enable from downstream; a beat transfers when v_down & e_down.

Behaviour:
- State:
  - shift register sr[IN_W].
  - beat counter cnt, width $clog2(RATIO).
  - occupancy flag v_l.
- Reset (rst_n=0 at posedge):
  - v_l=0, cnt=0, sr=0.
  - Outputs after reset: v_down=0, last_down=0, d_down=0, e_up=1.
- Combinational outputs:
  - v_down = v_l.
  - last_down = v_l & (cnt == RATIO-1).
  - d_down = sr[OUT_W-1:0] when MSB_FIRST=0, sr[IN_W-1:IN_W-OUT_W] when MSB_FIRST=1.
  - e_up = ~v_l | (e_down & last_down).
  - e_up depends combinationally on e_down; the enable path is not registered here.
- Idle (v_l=0) with v_up=1: load sr=d_up, cnt=0, v_l=1. First beat is visible on the next cycle, so input-to-first-beat latency is 1 cycle.
- Busy, beat accepted (v_down & e_down), cnt < RATIO-1:
  - shift sr by OUT_W (right for LSB-first, left for MSB-first, zero fill).
  - cnt += 1.
- Busy, last beat accepted:
  - if v_up=1: load the new word into sr, cnt=0, v_l stays 1. This is back-to-back operation with no bubble.
  - if v_up=0: v_l=0, cnt=0.
- Busy, e_down=0: sr, cnt and v_l hold. d_down, v_down and last_down stay stable, and e_up=0.
- v_up asserted while busy and not on the accepted last beat: no transfer; upstream holds its word.
- d_up is sampled only on a word transfer; it is don't-care otherwise.
- cnt never exceeds RATIO-1; it wraps to 0 only via load or the empty transition.
- Reset mid-word: the partial word is discarded, no further beats are emitted, and e_up=1 on the cycle after reset.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles with v_up=1, d_up=0xDEADBEEF -> during reset and the cycle after, v_down=0 and e_up=1; no beat is ever emitted from the word presented during reset.
- Single word, LSB-first, e_down=1: v_up pulse with 0x44332211 -> v_down high for 4 consecutive cycles starting 1 cycle later, d_down=0x11,0x22,0x33,0x44, last_down only on 0x44; e_up=0 for the first 3 beat cycles and 1 on the last.
- Back-to-back, e_down=1: v_up held with words 0xA3A2A1A0 then 0xB3B2B1B0 -> 8 contiguous beats A0..A3, B0..B3 with no gap; the second word transfers on the cycle of beat A3.
- Backpressure: same as the single-word case but e_down=0 for 3 cycles while beat 0x22 is shown -> d_down holds 0x22, cnt holds and e_up=0 throughout; the sequence resumes 0x33, 0x44 after e_down=1.
- MSB_FIRST=1: word 0x44332211 -> beats 0x44,0x33,0x22,0x11, last_down on 0x11.
- Reset mid-word: assert rst_n=0 after beat 0x22 -> the next cycle shows v_down=0 and last_down=0; a new word 0x0000CAFE then yields 0xFE,0xCA,0x00,0x00.
